register_bank_module: RTL and testbench

Parametrised bank of general-purpose bus registers for the 8-bit computer, replacing single-register instances where several registers share the tristate system bus. Each register loads from or drives the bus, and counts up or down in place. Separate input and output selects allow a register-to-register transfer across the bus in one clock. Status outputs give a zero indication and a registered wrap pulse for the control sequencer.

---
 rtl/register_bank_module.sv | 88 ++++++++
 tb/tb_register_bank_module.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/register_bank_module.sv
// Bank of bus registers: per-register load/inc/dec cells sharing one tristate bus,
// with a combinational zero flag on the read port and a registered wrap pulse.

module register_bank_cell #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic             ie,
  input  logic             inc,
  input  logic             dec,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             wrap_nxt
);
  logic up, dn;

  // A load beats counting; inc and dec together cancel.
  assign up       = sel && !ie && inc && !dec;
  assign dn       = sel && !ie && dec && !inc;
  assign wrap_nxt = (up && (q == '1)) || (dn && (q == '0));

  always_ff @(posedge clk) begin
    if (!rst)            q <= RESET_VALUE;
    else if (sel && ie)  q <= din;
    else if (up)         q <= q + WIDTH'(1);
    else if (dn)         q <= q - WIDTH'(1);
  end
endmodule

module register_bank_module #(
  parameter int               WIDTH       = 8,
  parameter int               DEPTH       = 4,
  parameter int               SELW        = $clog2(DEPTH),
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SELW-1:0]        isel,
  input  logic [SELW-1:0]        osel,
  input  logic                   ie,
  input  logic                   oe,
  input  logic                   inc,
  input  logic                   dec,
  output logic [DEPTH*WIDTH-1:0] data,
  inout  wire  [WIDTH-1:0]       bus,
  output logic                   zero,
  output logic                   wrap
);
  logic [DEPTH-1:0][WIDTH-1:0] regs;
  logic [DEPTH-1:0]            cell_wrap;
  logic [WIDTH-1:0]            rd;

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_cell
      register_bank_cell #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_cell (
        .clk     (clk),
        .rst     (rst),
        .sel     (isel == SELW'(i)),
        .ie      (ie),
        .inc     (inc),
        .dec     (dec),
        .din     (bus),
        .q       (regs[i]),
        .wrap_nxt(cell_wrap[i])
      );
    end
  endgenerate

  // Out-of-range osel matches nothing and reads as zero.
  always_comb begin
    rd = '0;
    for (int k = 0; k < DEPTH; k++)
      if (osel == SELW'(k)) rd = regs[k];
  end

  assign data = regs;
  assign zero = (rd == '0);
  assign bus  = oe ? rd : {WIDTH{1'bz}};

  always_ff @(posedge clk) begin
    if (!rst) wrap <= 1'b0;
    else      wrap <= |cell_wrap;
  end
endmodule

// File: tb/tb_register_bank_module.sv
// Scoreboard bench: stimulus queues expected post-edge values, monitor checks them at negedge.

module tb_register_bank_module;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  isel = '0, osel = '0;
  logic        ie = 1'b0, oe = 1'b0, inc = 1'b0, dec = 1'b0;
  logic [31:0] data;
  wire  [7:0]  bus;
  logic        zero, wrap;
  logic        drv_en = 1'b0;
  logic [7:0]  drv_val = '0;

  assign bus = drv_en ? drv_val : 8'bz;

  always #5 clk = ~clk;

  register_bank_module #(.WIDTH(8), .DEPTH(4), .RESET_VALUE(8'h00)) dut (
    .clk(clk), .rst(rst), .isel(isel), .osel(osel), .ie(ie), .oe(oe),
    .inc(inc), .dec(dec), .data(data), .bus(bus), .zero(zero), .wrap(wrap)
  );

  typedef struct {
    string       name;
    int          kind;   // 0 data, 1 wrap, 2 zero, 3 bus
    logic [31:0] v;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.kind)
        0:       act = data;
        1:       act = {31'd0, wrap};
        2:       act = {31'd0, zero};
        default: act = {24'd0, bus};
      endcase
      checks++;
      if (act !== e.v) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.v);
      end
    end
  end

  task automatic push(input string n, input int k, input logic [31:0] v);
    exp_t e;
    e.name = n; e.kind = k; e.v = v;
    q.push_back(e);
  endtask

  // One clock: expectations describe state right after the edge.
  task automatic step(input string n, input logic [31:0] d, input logic w,
                      input logic z, input logic chk_bus, input logic [7:0] b);
    @(posedge clk); #1;
    push({n, ".data"}, 0, d);
    push({n, ".wrap"}, 1, {31'd0, w});
    push({n, ".zero"}, 2, {31'd0, z});
    if (chk_bus) push({n, ".bus"}, 3, {24'd0, b});
    @(negedge clk); #1;
  endtask

  task automatic drive(input logic [7:0] v);
    drv_en = 1'b1; drv_val = v;
  endtask

  task automatic release_bus();
    drv_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held two clocks with a load pending
    rst = 1'b0; ie = 1'b1; drive(8'hAA);
    step("rst1", 32'h0, 1'b0, 1'b1, 1'b0, 8'h0);
    step("rst2", 32'h0, 1'b0, 1'b1, 1'b0, 8'h0);
    rst = 1'b1;

    // Load reg2 from bus, then drive it back out
    isel = 2'd2; drive(8'h5C);
    step("load2", 32'h005C_0000, 1'b0, 1'b1, 1'b0, 8'h0);
    release_bus(); ie = 1'b0; oe = 1'b1; osel = 2'd2;
    step("drive2", 32'h005C_0000, 1'b0, 1'b0, 1'b1, 8'h5C);

    // Transfer reg1 -> reg3, then self transfer
    oe = 1'b0; isel = 2'd1; ie = 1'b1; drive(8'h3F);
    step("load1", 32'h005C_3F00, 1'b0, 1'b0, 1'b0, 8'h0);
    release_bus(); oe = 1'b1; osel = 2'd1; isel = 2'd3;
    step("xfer13", 32'h3F5C_3F00, 1'b0, 1'b0, 1'b1, 8'h3F);
    isel = 2'd1;
    step("xfer11", 32'h3F5C_3F00, 1'b0, 1'b0, 1'b1, 8'h3F);

    // Count up through wrap, then down through wrap
    oe = 1'b0; osel = 2'd0; isel = 2'd0; drive(8'hFE);
    step("loadFE", 32'h3F5C_3FFE, 1'b0, 1'b0, 1'b0, 8'h0);
    release_bus(); ie = 1'b0; inc = 1'b1;
    step("incFF", 32'h3F5C_3FFF, 1'b0, 1'b0, 1'b0, 8'h0);
    step("inc00", 32'h3F5C_3F00, 1'b1, 1'b1, 1'b0, 8'h0);
    inc = 1'b0; dec = 1'b1;
    step("decFF", 32'h3F5C_3FFF, 1'b1, 1'b0, 1'b0, 8'h0);
    dec = 1'b0;
    step("idle", 32'h3F5C_3FFF, 1'b0, 1'b0, 1'b0, 8'h0);

    // Priority: load beats inc, inc+dec holds
    ie = 1'b1; drive(8'h10);
    step("load10", 32'h3F5C_3F10, 1'b0, 1'b0, 1'b0, 8'h0);
    drive(8'h77); inc = 1'b1;
    step("ldinc", 32'h3F5C_3F77, 1'b0, 1'b0, 1'b0, 8'h0);
    release_bus(); ie = 1'b0; dec = 1'b1;
    step("incdec", 32'h3F5C_3F77, 1'b0, 1'b0, 1'b0, 8'h0);

    // Back-to-back wraps; a load of 00 over FF never wraps
    inc = 1'b0; dec = 1'b0; ie = 1'b1; drive(8'hFF);
    step("loadFF", 32'h3F5C_3FFF, 1'b0, 1'b0, 1'b0, 8'h0);
    release_bus(); ie = 1'b0; inc = 1'b1;
    step("bb_inc", 32'h3F5C_3F00, 1'b1, 1'b1, 1'b0, 8'h0);
    inc = 1'b0; dec = 1'b1;
    step("bb_dec", 32'h3F5C_3FFF, 1'b1, 1'b0, 1'b0, 8'h0);
    dec = 1'b0; ie = 1'b1; drive(8'h00);
    step("ld00", 32'h3F5C_3F00, 1'b0, 1'b1, 1'b0, 8'h0);

    // Reset mid-count on reg2
    isel = 2'd2; drive(8'h05);
    step("load05", 32'h3F05_3F00, 1'b0, 1'b1, 1'b0, 8'h0);
    release_bus(); ie = 1'b0; inc = 1'b1;
    step("cnt06", 32'h3F06_3F00, 1'b0, 1'b1, 1'b0, 8'h0);
    step("cnt07", 32'h3F07_3F00, 1'b0, 1'b1, 1'b0, 8'h0);
    rst = 1'b0;
    step("midrst", 32'h0, 1'b0, 1'b1, 1'b0, 8'h0);
    rst = 1'b1;
    step("resume", 32'h0001_0000, 1'b0, 1'b1, 1'b0, 8'h0);
    inc = 1'b0;

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
